// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter, instruction register and fetch sequencer.
// The unit alternates FETCH (request imem, wait for ready, latch IR) and EXEC
// (present IR, wait for any data-memory stall, commit next PC).
// Optional feature macro: FETCH_ALIGN_CHECK_EN
//   defined   -> a misaligned commit target loads PC unmodified, raises fault
//                and parks the unit in HALT until reset.
//   undefined -> the target's low two bits are cleared, fault is tied low and
//                HALT is never entered.
module pc_fetch_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  Branch,
  input  logic [31:0] rs_data,
  input  logic        mem_stall,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] inst_out,
  output logic        inst_valid,
  output logic [31:0] PC_out,
  output logic [31:0] PC4_out,
  output logic [31:0] inst_count,
  output logic        fault
);

  localparam int unsigned XLEN     = 32;
  localparam int unsigned IMM_W    = 16;
  localparam int unsigned JIDX_W   = 26;
  localparam int unsigned REGION_W = 4;
  localparam int unsigned SEXT_W   = XLEN - IMM_W - 2;

  localparam logic [1:0] BR_SEQ    = 2'b00;
  localparam logic [1:0] BR_OFFSET = 2'b01;
  localparam logic [1:0] BR_JUMP   = 2'b10;
  localparam logic [1:0] BR_REG    = 2'b11;

  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] cnt_q, cnt_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] br_offset;
  logic [XLEN-1:0] jump_target;
  logic [XLEN-1:0] target_pc;

`ifdef FETCH_ALIGN_CHECK_EN
  logic            fault_q, fault_d;
  logic            misaligned;
`endif

  // Sequential PC and the two static target forms derived from PC and IR.
  assign pc_plus4    = pc_q + PC_STEP;
  assign br_offset   = {{SEXT_W{ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0], 2'b00};
  assign jump_target = {pc_plus4[XLEN-1:XLEN-REGION_W], ir_q[JIDX_W-1:0], 2'b00};

  // Next-PC select; only consumed at the commit edge.
  always_comb begin
    target_pc = pc_plus4;
    case (Branch)
      BR_SEQ:    target_pc = pc_plus4;
      BR_OFFSET: target_pc = pc_plus4 + br_offset;
      BR_JUMP:   target_pc = jump_target;
      BR_REG:    target_pc = rs_data;
      default:   target_pc = pc_plus4;
    endcase
  end

`ifdef FETCH_ALIGN_CHECK_EN
  assign misaligned = |target_pc[1:0];
`endif

  // State register and architectural registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b1;
      valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      valid_q <= valid_d;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q <= fault_d;
`endif
    end
  end

  // Next-state, register updates and registered handshake outputs.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    valid_d = valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
    fault_d = fault_q;
`endif

    case (state_q)
      ST_FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_data;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        // A data access in flight freezes the instruction in place.
        if (!mem_stall) begin
`ifdef FETCH_ALIGN_CHECK_EN
          pc_d = target_pc;
          if (misaligned) begin
            fault_d = 1'b1;
            state_d = ST_HALT;
          end else begin
            cnt_d   = cnt_q + XLEN'(1);
            state_d = ST_FETCH;
          end
`else
          pc_d    = target_pc & ALIGN_MASK;
          cnt_d   = cnt_q + XLEN'(1);
          state_d = ST_FETCH;
`endif
        end
      end

      ST_HALT: begin
`ifdef FETCH_ALIGN_CHECK_EN
        state_d = ST_HALT;
`else
        state_d = ST_FETCH;
`endif
      end

      default: state_d = ST_FETCH;
    endcase

    // Handshake flags follow the state being entered so they are flop outputs.
    req_d   = (state_d == ST_FETCH);
    valid_d = (state_d == ST_EXEC);
  end

  // Output mapping; fetch address tracks PC in every state.
  assign imem_req   = req_q;
  assign inst_valid = valid_q;
  assign imem_addr  = pc_q;
  assign PC_out     = pc_q;
  assign PC4_out    = pc_plus4;
  assign inst_out   = ir_q;
  assign inst_count = cnt_q;

`ifdef FETCH_ALIGN_CHECK_EN
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed stimulus with a scoreboard queue of expected
// {PC, IR, count} per instruction, checked by an independent negedge monitor.
module tb_pc_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] cnt;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  Branch;
  logic [31:0] rs_data;
  logic        mem_stall;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] inst_out;
  logic        inst_valid;
  logic [31:0] PC_out;
  logic [31:0] PC4_out;
  logic [31:0] inst_count;
  logic        fault;

  exp_t exp_q[$];
  exp_t cur;
  int   n_cmp;
  int   n_err;

  pc_fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Branch     (Branch),
    .rs_data    (rs_data),
    .mem_stall  (mem_stall),
    .imem_ready (imem_ready),
    .imem_data  (imem_data),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .inst_out   (inst_out),
    .inst_valid (inst_valid),
    .PC_out     (PC_out),
    .PC4_out    (PC4_out),
    .inst_count (inst_count),
    .fault      (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One instruction: optional fetch wait, optional stall, then commit or mid-stall reset.
  task automatic run_instr(input logic [31:0] exp_pc, input logic [31:0] data,
                           input logic [1:0] br, input logic [31:0] rs,
                           input int rdelay, input int stalls,
                           input logic [31:0] exp_cnt, input bit reset_mid);
    exp_t e;
    e.pc   = exp_pc;
    e.inst = data;
    e.cnt  = exp_cnt;
    exp_q.push_back(e);
    imem_ready = 1'b0;
    imem_data  = 32'hDEADBEEF;
    repeat (rdelay) tick();
    imem_ready = 1'b1;
    imem_data  = data;
    tick();
    // In EXEC: imem traffic and off-commit Branch/rs_data must be ignored.
    imem_data  = 32'hBAD0BAD0;
    Branch     = ~br;
    rs_data    = ~rs;
    mem_stall  = 1'b1;
    repeat (stalls) tick();
    if (reset_mid) begin
      rst_n = 1'b0;
      tick();
      chk("midrst_pc", PC_out, 32'h0);
      chk("midrst_cnt", inst_count, 32'h0);
      chk("midrst_ir", inst_out, 32'h0);
      chk("midrst_valid", 32'(inst_valid), 32'h0);
      chk("midrst_req", 32'(imem_req), 32'h1);
      chk("midrst_fault", 32'(fault), 32'h0);
      rst_n     = 1'b1;
      mem_stall = 1'b0;
      imem_ready = 1'b0;
      tick();
    end else begin
      mem_stall  = 1'b0;
      imem_ready = 1'b0;
      Branch     = br;
      rs_data    = rs;
      tick();
    end
  endtask

  // Monitor: pops on each new instruction, holds it across stall cycles.
  initial begin
    bit prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
      end else if (inst_valid) begin
        if (!prev_v) begin
          if (exp_q.size() == 0) begin
            n_cmp = n_cmp + 1;
            n_err = n_err + 1;
            $display("FAIL unexpected_exec: got inst %h expected none", inst_out);
          end else begin
            cur = exp_q.pop_front();
          end
        end
        chk("exec_pc", PC_out, cur.pc);
        chk("exec_pc4", PC4_out, cur.pc + 32'd4);
        chk("exec_ir", inst_out, cur.inst);
        chk("exec_cnt", inst_count, cur.cnt);
        chk("exec_req", 32'(imem_req), 32'h0);
        prev_v = 1'b1;
      end else begin
        prev_v = 1'b0;
        if (exp_q.size() != 0) begin
          chk("fetch_addr", imem_addr, exp_q[0].pc);
          chk("fetch_req", 32'(imem_req), 32'h1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Directed stimulus with hand-computed expectations.
  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    Branch     = 2'b00;
    rs_data    = 32'h0;
    mem_stall  = 1'b1;
    imem_ready = 1'b1;
    imem_data  = 32'hFFFFFFFF;
    repeat (2) tick();
    chk("rst_req", 32'(imem_req), 32'h1);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_ir", inst_out, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_pc", PC_out, 32'h0);
    chk("rst_pc4", PC4_out, 32'h4);
    chk("rst_cnt", inst_count, 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    rst_n     = 1'b1;
    mem_stall = 1'b0;

    run_instr(32'h00000000, 32'h20080005, 2'b00, 32'h0,        0, 0, 32'd0, 1'b0);
    run_instr(32'h00000004, 32'h00000020, 2'b00, 32'h0,        0, 0, 32'd1, 1'b0);
    run_instr(32'h00000008, 32'h00000000, 2'b00, 32'h0,        0, 0, 32'd2, 1'b0);
    run_instr(32'h0000000C, 32'hAAAA5555, 2'b11, 32'h10,       4, 3, 32'd3, 1'b0);
    run_instr(32'h00000010, 32'h1000FFFE, 2'b01, 32'h0,        0, 0, 32'd4, 1'b0);
    run_instr(32'h0000000C, 32'h12345678, 2'b11, 32'h10000000, 0, 0, 32'd5, 1'b0);
    run_instr(32'h10000000, 32'h08000040, 2'b10, 32'h0,        0, 1, 32'd6, 1'b0);
    run_instr(32'h10000100, 32'h00000000, 2'b11, 32'hFFFFFFFC, 0, 0, 32'd7, 1'b0);
    run_instr(32'hFFFFFFFC, 32'h00000000, 2'b00, 32'h0,        0, 0, 32'd8, 1'b0);
    chk("wrap_pc", PC_out, 32'h0);
    run_instr(32'h00000000, 32'h03E00008, 2'b11, 32'h46,       0, 0, 32'd9, 1'b0);

`ifdef FETCH_ALIGN_CHECK_EN
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("halt_pc", PC_out, 32'h46);
      chk("halt_fault", 32'(fault), 32'h1);
      chk("halt_req", 32'(imem_req), 32'h0);
      chk("halt_valid", 32'(inst_valid), 32'h0);
      chk("halt_cnt", inst_count, 32'd9);
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("halt_exit_fault", 32'(fault), 32'h0);
    run_instr(32'h00000000, 32'h00000001, 2'b00, 32'h0, 0, 0, 32'd0, 1'b0);
    run_instr(32'h00000004, 32'h00000002, 2'b00, 32'h0, 0, 2, 32'd1, 1'b1);
`else
    chk("align_pc", PC_out, 32'h44);
    chk("align_fault", 32'(fault), 32'h0);
    run_instr(32'h00000044, 32'h11111111, 2'b00, 32'h0, 0, 2, 32'd10, 1'b1);
`endif

    repeat (2) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
